// File: rtl/phys_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// phys_mem_arb_pkg: shared types and constants for the I/D memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package phys_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      ABORT   = 2'd3
   } arb_state_t;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int DEF_TIMEOUT = 64;

endpackage

`default_nettype wire

// File: rtl/phys_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2: two-input round-robin picker; the pointer only moves on contention
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2
   import phys_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       set_en,
   input  logic       set_ptr,
   output logic       gnt_idx,
   output logic       gnt_valid
);

   logic rr_ptr_q;
   logic rr_ptr_d;

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = (&req) ? rr_ptr_q : req[PORT_D];
   end

   // An uncontested grant leaves the pointer alone so fairness is only spent
   // when both ports actually competed.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (set_en) begin
         rr_ptr_d = set_ptr;
      end else if (advance && (&req)) begin
         rr_ptr_d = ~rr_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= PORT_I;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/phys_mem_arbiter.sv
// ---------------------------------------------------------------------------
// phys_mem_arbiter: round-robin share of the physical memory bus between the
// I-cache and D-cache controllers, with an unacknowledged-strobe watchdog.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phys_mem_arbiter
   import phys_mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              i_cyc,
   input  logic              i_stb,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LINE_W-1:0] i_wdata,
   output logic              i_ack,
   output logic              i_rty,

   input  logic              d_cyc,
   input  logic              d_stb,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_rty,

   output logic [LINE_W-1:0] rdata,

   output logic              mem_cyc,
   output logic              mem_stb,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic              mem_rty
);

   arb_state_t state_q;
   arb_state_t state_d;
   logic       owner_q;
   logic       owner_d;

   logic [1:0] w_req;
   logic       w_gnt_idx;
   logic       w_gnt_valid;
   logic       w_granted;
   logic       w_wd_abort;

   assign w_req[PORT_I] = i_cyc & i_stb;
   assign w_req[PORT_D] = d_cyc & d_stb;
   assign w_granted     = (state_q == GRANT_I) || (state_q == GRANT_D);

   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (w_req),
      .advance   (state_q == IDLE),
      .set_en    (state_q == ABORT),
      .set_ptr   (~owner_q),
      .gnt_idx   (w_gnt_idx),
      .gnt_valid (w_gnt_valid)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (w_gnt_valid) begin
               owner_d = w_gnt_idx;
               state_d = (w_gnt_idx == PORT_D) ? GRANT_D : GRANT_I;
            end
         end
         GRANT_I: begin
            if (!i_cyc) begin
               state_d = IDLE;
            end else if (w_wd_abort) begin
               state_d = ABORT;
            end
         end
         GRANT_D: begin
            if (!d_cyc) begin
               state_d = IDLE;
            end else if (w_wd_abort) begin
               state_d = ABORT;
            end
         end
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= PORT_I;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // The bus is a pure mux on the registered state, so an async reset drops
   // mem_cyc/mem_stb the moment rst_n falls.
   always_comb begin
      mem_cyc   = 1'b0;
      mem_stb   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_ack     = 1'b0;
      i_rty     = 1'b0;
      d_ack     = 1'b0;
      d_rty     = 1'b0;
      case (state_q)
         GRANT_I: begin
            mem_cyc   = i_cyc;
            mem_stb   = i_stb;
            mem_we    = i_we;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
            i_ack     = mem_ack;
            i_rty     = mem_rty;
         end
         GRANT_D: begin
            mem_cyc   = d_cyc;
            mem_stb   = d_stb;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_ack     = mem_ack;
            d_rty     = mem_rty;
         end
         ABORT: begin
            i_rty = (owner_q == PORT_I);
            d_rty = (owner_q == PORT_D);
         end
         default: ;
      endcase
   end

   assign rdata = mem_rdata;

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int WD_W = $clog2(TIMEOUT + 1);
         localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
         localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

         logic [WD_W-1:0] wd_cnt_q;
         logic [WD_W-1:0] wd_cnt_d;
         logic            w_stall;

         assign w_stall = w_granted && mem_stb && !mem_ack;

         // A same-cycle ack masks the terminal count, so a late ack still wins.
         assign w_wd_abort = w_stall && (wd_cnt_q == WD_LAST);

         always_comb begin
            wd_cnt_d = '0;
            if (w_stall) begin
               wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wd_cnt_q <= '0;
            end else begin
               wd_cnt_q <= wd_cnt_d;
            end
         end
      end else begin : g_no_wd
         assign w_wd_abort = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire
